// File: rtl/mul8_seq_ctrl.sv
// rtl/mul8_seq_ctrl.sv - 8x8 unsigned multiply sequenced over a shared 4x4 array
// One nibble-pair product per cycle is accumulated over four MUL cycles.

module wallace (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  always_comb begin
    p_o = '0;
    for (int i = 0; i < 4; i++) begin
      if (b_i[i]) p_o = p_o + ({4'b0, a_i} << i);
    end
  end
endmodule

module mul8_seq_ctrl #(
  parameter bit CLEAR_ON_START = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] prod_o
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  aq_q, aq_d, bq_q, bq_d;
  logic [15:0] acc_q, acc_d, prod_q, prod_d;

  logic [3:0]  wa, wb;
  logic [7:0]  pp;
  logic [15:0] term;

  // cnt[0] picks the high nibble of a, cnt[1] the high nibble of b
  assign wa = cnt_q[0] ? aq_q[7:4] : aq_q[3:0];
  assign wb = cnt_q[1] ? bq_q[7:4] : bq_q[3:0];

  wallace u_wallace (
    .a_i (wa),
    .b_i (wb),
    .p_o (pp)
  );

  always_comb begin
    case (cnt_q)
      2'd0:    term = {8'b0, pp};
      2'd3:    term = {pp, 8'b0};
      default: term = {4'b0, pp, 4'b0};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    aq_d    = aq_q;
    bq_d    = bq_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    case (state_q)
      S_MUL: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == 2'd3) begin
          prod_d  = acc_q + term;
          state_d = S_DONE;
        end else begin
          acc_d = acc_q + term;
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start_i) begin
          aq_d    = a_i;
          bq_d    = b_i;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_MUL;
          if (CLEAR_ON_START) prod_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      aq_q    <= '0;
      bq_q    <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      aq_q    <= aq_d;
      bq_q    <= bq_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  assign busy_o = (state_q == S_MUL);
  assign done_o = (state_q == S_DONE);
  assign prod_o = prod_q;
endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// tb/tb_mul8_seq_ctrl.sv - directed and random checks of mul8_seq_ctrl against a*b
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.

module tb_mul8_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [7:0]  a, b;
  logic        busy, done;
  logic [15:0] prod;

  int checks = 0;
  int errors = 0;

  mul8_seq_ctrl #(.CLEAR_ON_START(1'b1)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .abort_i (abort),
    .a_i     (a),
    .b_i     (b),
    .busy_o  (busy),
    .done_o  (done),
    .prod_o  (prod)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full operation with start pulsed for one cycle; checks busy window, done and product.
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib);
    logic [15:0] exp;
    exp = 16'(ia) * 16'(ib);
    a = ia; b = ib; start = 1'b1;
    step();
    start = 1'b0;
    a = ~ia; b = ~ib;
    chk("op_busy0", {15'b0, busy}, 16'd1);
    chk("op_clr", prod, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("op_busy", {15'b0, busy}, 16'd1);
      chk("op_nodone", {15'b0, done}, 16'd0);
    end
    step();
    chk("op_done", {15'b0, done}, 16'd1);
    chk("op_idle", {15'b0, busy}, 16'd0);
    chk("op_prod", prod, exp);
    step();
    chk("op_done_end", {15'b0, done}, 16'd0);
    chk("op_hold", prod, exp);
  endtask

  initial begin
    int dcount;
    logic [15:0] exp;
    rst = 1'b1; start = 1'b0; abort = 1'b0; a = '0; b = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_busy", {15'b0, busy}, 16'd0);
    chk("rst_done", {15'b0, done}, 16'd0);
    chk("rst_prod", prod, 16'h0000);

    run_op(8'hFF, 8'hFF);
    run_op(8'h12, 8'h34);
    run_op(8'h00, 8'hA5);
    run_op(8'h80, 8'h02);

    // start pulsed while busy must be ignored
    a = 8'h0F; b = 8'h0F; start = 1'b1;
    step();
    start = 1'b0;
    step();
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        dcount++;
        chk("ign_prod", prod, 16'h00E1);
      end
      step();
    end
    chk("ign_ndone", 16'(dcount), 16'd1);
    chk("ign_final", prod, 16'h00E1);

    // abort the cycle after acceptance
    a = 8'h55; b = 8'h33; start = 1'b1;
    step();
    start = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abt_busy", {15'b0, busy}, 16'd0);
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      dcount += int'(done);
      step();
    end
    chk("abt_ndone", 16'(dcount), 16'd0);
    chk("abt_prod", prod, 16'h0000);

    // abort and start together in DONE: pulse completes, start accepted
    a = 8'h12; b = 8'h34; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    step();
    chk("dn_done", {15'b0, done}, 16'd1);
    chk("dn_prod", prod, 16'h03A8);
    abort = 1'b1; start = 1'b1; a = 8'h09; b = 8'h09;
    step();
    abort = 1'b0; start = 1'b0;
    chk("dn_accept", {15'b0, busy}, 16'd1);
    step(); step(); step();
    step();
    chk("dn_done2", {15'b0, done}, 16'd1);
    chk("dn_prod2", prod, 16'd81);
    step();

    // reset on the third MUL cycle
    a = 8'hAB; b = 8'hCD; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_busy", {15'b0, busy}, 16'd0);
    chk("mrst_done", {15'b0, done}, 16'd0);
    chk("mrst_prod", prod, 16'h0000);
    dcount = 0;
    for (int i = 0; i < 5; i++) begin
      dcount += int'(done);
      step();
    end
    chk("mrst_ndone", 16'(dcount), 16'd0);
    run_op(8'd3, 8'd7);

    // start held high: one result every 5 cycles, new a/b driven while busy
    a = 8'($urandom); b = 8'($urandom); start = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      exp = 16'(a) * 16'(b);
      step();
      a = 8'($urandom); b = 8'($urandom);
      chk("bb_busy", {15'b0, busy}, 16'd1);
      for (int i = 0; i < 3; i++) begin
        step();
        chk("bb_nodone", {15'b0, done}, 16'd0);
      end
      step();
      chk("bb_done", {15'b0, done}, 16'd1);
      chk("bb_prod", prod, exp);
    end
    start = 1'b0;
    step();
    chk("bb_end", {15'b0, busy}, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
